ps2_mouse_dev: RTL and testbench
================================

# ps2_mouse_dev

Device-side PS/2 mouse emulator: the opposite end of the host-side PS/2 mouse controller. Generates the PS/2 clock, serialises 3-byte movement packets, and receives and answers host commands (reset, enable/disable reporting, get ID). Used wherever internal motion sources (MSX mouse/trackball, OSD pointer, bench stimulus) must appear as a standard PS/2 mouse to a PS/2 host.

## Interface
Parameters:
- DIV_HALF, 1074 — clk cycles per PS/2 clock half-period (≈10 kHz at 21.48 MHz).
- INHIBIT_MIN, 2148 — clk cycles ps2_clk must be held low by the host to count as inhibit/request-to-send.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ps2mclk  inout  1  PS/2 clock, open-collector (drive 0 or Z).
- ps2mdat  inout  1  PS/2 data, open-collector.
- pkt_valid  in  1  movement packet offered.
- pkt_ready  out  1  packet accepted when pkt_valid & pkt_ready.
- pkt_btn  in  3  {middle, right, left}, 1 = pressed.
- pkt_dx  in  9  signed X delta, right positive.
- pkt_dy  in  9  signed Y delta, up positive.
- enabled  out  1  data reporting enabled (after host 0xF4).
- cmd_valid  out  1  one-cycle pulse: host byte received with good parity.
- cmd_byte  out  8  last received host byte.
- rx_err  out  1  one-cycle pulse: host byte parity/stop error.

## Operation
- Reset values: ps2 lines Z, pkt_ready 0, enabled 0, cmd_valid 0, cmd_byte 0x00, rx_err 0. After reset release, queue BAT response 0xAA, 0x00.
- Both ps2 inputs pass a 2-flop synchroniser before any use.
- Response queue: 3 bytes, FIFO. Host command replaces the queue contents; pending packet bytes are discarded.
- Commands: 0xFF → FA,AA,00, enabled=0; 0xF4 → FA, enabled=1; 0xF5 → FA, enabled=0; 0xF6 → FA, enabled=0; 0xF2 → FA,00; 0xFE → resend last transmitted byte; any other → FA. Parity error → FE, rx_err pulse, cmd_valid not pulsed.
- pkt_ready = 1 only in IDLE with empty queue and no host activity. If enabled=0 the accepted packet is dropped; else queue {0,0,dy[8],dx[8],1,btn}, dx[7:0], dy[7:0]. Overflow bits are always 0.
- States: IDLE, TX_HI, TX_LO, TX_GAP, RX_WAIT, RX_LO, RX_HI, RX_ACK.
- IDLE: queue non-empty and ps2mclk high → TX_HI (bit 0). ps2mclk low ≥ INHIBIT_MIN → RX_WAIT.
- TX frame: start 0, 8 data LSB first, odd parity, stop 1. TX_HI drives data for the bit, clock released, DIV_HALF cycles; TX_LO drives clock low DIV_HALF cycles; host samples on falling edge. After stop bit → TX_GAP (2·DIV_HALF cycles, clock and data released) → IDLE; byte popped at the start of TX_GAP.
- Inhibit during TX: synchronised clock low at the end of any TX_HI before bit 10 → abort, release both lines, byte stays at queue head, go to RX_WAIT. Clock low after bit 10 sent: byte counts as sent.
- RX_WAIT: clock released with data low → RX_LO; clock released with data high → IDLE (retransmit head).
- RX: 10 cycles of RX_LO (clock low DIV_HALF) / RX_HI (released DIV_HALF, sample data at mid-high): 8 data, parity, stop. Then RX_ACK: drive data low for one clock cycle (low+high), release → evaluate byte → IDLE.

## Timing
- Packet accept to start-bit data drive: 1 cycle; first falling clock edge DIV_HALF cycles later.
- Byte period 22·DIV_HALF cycles plus 2·DIV_HALF gap; 3-byte packet ≈72·DIV_HALF cycles.
- cmd_valid/rx_err asserted in the cycle after the ACK clock release; response TX starts no sooner than TX_GAP length later.
- reset_n low mid-frame: lines released immediately; queue cleared, BAT re-queued.
- pkt_valid with pkt_ready low: no effect; source holds.

## Structure
- Package ps2_pkg: command codes (FF, FE, F6, F5, F4, F2), response codes (FA, AA, FE, 00), state enum, odd-parity function.
- Sub-module ps2_dev_phy: clock generation, bit serialiser/deserialiser, inhibit detection; exposes byte tx valid/done/abort and rx valid/err. Top holds queue, command decode, packet handshake.

## Test plan
- Reset release, host model idle → device sends 0xAA then 0x00, parity bits 1 and 1, enabled=0.
- Host sends 0xF4 → FA returned, enabled=1, cmd_valid with cmd_byte=0xF4.
- enabled=1, packet btn=3'b001, dx=+5, dy=−3 → bytes 0x29, 0x05, 0xFD.
- Host pulls clock low at bit 4 of byte 0x05 → abort, lines released; after release, 0x05 resent in full.
- Host sends 0xF2 with bad parity → FE returned, rx_err pulse; then 0xF2 good → FA, 00.
- enabled=0, packet offered → accepted, no clock activity for 100·DIV_HALF cycles.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 mouse-device command/response codes, FSM states and parity helper.
package ps2_pkg;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;
  localparam logic [7:0] CMD_DEFAULTS = 8'hF6;
  localparam logic [7:0] CMD_DISABLE  = 8'hF5;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT      = 8'hAA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ID       = 8'h00;
  typedef enum logic [2:0] {IDLE, TX_HI, TX_LO, TX_GAP, RX_WAIT, RX_LO, RX_HI, RX_ACK} state_t;
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_dev_phy.sv
// ps2_dev_phy: device-side PS/2 line engine -- clock generation, byte serialiser/deserialiser,
// host inhibit / request-to-send detection.
module ps2_dev_phy
  import ps2_pkg::*;
#(
  parameter int DIV_HALF    = 1074,
  parameter int INHIBIT_MIN = 2148
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_in,
  input  logic       dat_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       clk_low,
  output logic       dat_low,
  output logic       idle,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [7:0] rx_byte
);
  localparam int CMAX = (INHIBIT_MIN > 2 * DIV_HALF) ? INHIBIT_MIN : 2 * DIV_HALF;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV_HALF - 1);
  localparam logic [CW-1:0] FULL_END = CW'(2 * DIV_HALF - 1);
  localparam logic [CW-1:0] INH_END  = CW'(INHIBIT_MIN - 1);
  localparam logic [CW-1:0] MID      = CW'(DIV_HALF / 2);
  localparam logic [CW-1:0] HALF     = CW'(DIV_HALF);
  logic [1:0] clk_sync, dat_sync;
  logic clk_s, dat_s, half_end, full_end, rx_good;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [10:0] frame;
  logic [9:0] rx_sr;
  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign half_end = cnt == HALF_END;
  assign full_end = cnt == FULL_END;
  assign rx_good  = rx_sr[9] && rx_sr[8] == odd_par(rx_sr[7:0]);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (!clk_s && cnt >= INH_END) ? RX_WAIT : (clk_s && tx_valid) ? TX_HI : IDLE;
      TX_HI:   if (half_end) state_n = (!clk_s && bit_idx != 4'd10) ? RX_WAIT : TX_LO;
      TX_LO:   if (half_end) state_n = (bit_idx == 4'd10) ? TX_GAP : TX_HI;
      TX_GAP:  if (full_end) state_n = IDLE;
      RX_WAIT: if (clk_s) state_n = dat_s ? IDLE : RX_LO;
      RX_LO:   if (half_end) state_n = RX_HI;
      RX_HI:   if (half_end) state_n = (bit_idx == 4'd9) ? RX_ACK : RX_LO;
      RX_ACK:  if (full_end) state_n = TX_GAP;
      default: state_n = IDLE;
    endcase
  end
  assign tx_done = state == TX_LO && state_n == TX_GAP;
  assign clk_low = state == TX_LO || state == RX_LO || (state == RX_ACK && cnt < HALF);
  assign dat_low = ((state == TX_HI || state == TX_LO) && !frame[bit_idx]) || state == RX_ACK;
  assign idle    = state == IDLE && clk_s && dat_s;
  // In IDLE the counter only runs while the host holds the clock low (inhibit timer).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      rx_sr    <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_byte  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], clk_in};
      dat_sync <= {dat_sync[0], dat_in};
      state    <= state_n;
      cnt      <= (state_n != state || (state == IDLE && clk_s)) ? '0 : cnt + 1'b1;
      bit_idx  <= (state == IDLE || state == RX_WAIT) ? '0 :
                  ((state == TX_LO || state == RX_HI) && half_end) ? bit_idx + 1'b1 : bit_idx;
      if (state == IDLE) frame <= {1'b1, odd_par(tx_byte), tx_byte, 1'b0};
      if (state == RX_HI && cnt == MID) rx_sr <= {dat_s, rx_sr[9:1]};
      rx_valid <= state == RX_ACK && full_end && rx_good;
      rx_err   <= state == RX_ACK && full_end && !rx_good;
      if (state == RX_ACK && full_end) rx_byte <= rx_sr[7:0];
    end
  end
endmodule

// File: rtl/ps2_mouse_dev.sv
// ps2_mouse_dev: PS/2 mouse device emulator -- response queue, host command decode and
// movement packet handshake on top of the ps2_dev_phy line engine.
module ps2_mouse_dev
  import ps2_pkg::*;
#(
  parameter int DIV_HALF    = 1074,
  parameter int INHIBIT_MIN = 2148
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  wire        ps2mclk,
  inout  wire        ps2mdat,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  input  logic [2:0] pkt_btn,
  input  logic [8:0] pkt_dx,
  input  logic [8:0] pkt_dy,
  output logic       enabled,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       rx_err
);
  logic clk_low, dat_low, idle, tx_done, rx_valid, accept;
  logic [7:0] rx_byte, last_tx;
  logic [2:0][7:0] q;
  logic [1:0] q_cnt;
  assign ps2mclk   = clk_low ? 1'b0 : 1'bz;
  assign ps2mdat   = dat_low ? 1'b0 : 1'bz;
  assign pkt_ready = idle && q_cnt == 2'd0;
  assign accept    = pkt_valid && pkt_ready;
  assign cmd_valid = rx_valid;
  assign cmd_byte  = rx_byte;
  ps2_dev_phy #(.DIV_HALF(DIV_HALF), .INHIBIT_MIN(INHIBIT_MIN)) u_phy (
    .clk(clk), .reset_n(reset_n), .clk_in(ps2mclk), .dat_in(ps2mdat),
    .tx_valid(q_cnt != 2'd0), .tx_byte(q[0]), .tx_done(tx_done),
    .clk_low(clk_low), .dat_low(dat_low), .idle(idle),
    .rx_valid(rx_valid), .rx_err(rx_err), .rx_byte(rx_byte)
  );
  // Host traffic always replaces whatever was queued, including unsent packet bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= {RSP_ID, RSP_ID, RSP_BAT};
      q_cnt   <= 2'd2;
      enabled <= 1'b0;
      last_tx <= '0;
    end else if (rx_err) begin
      q[0]  <= RSP_RESEND;
      q_cnt <= 2'd1;
    end else if (rx_valid) begin
      q       <= {RSP_ID, (rx_byte == CMD_RESET) ? RSP_BAT : RSP_ID,
                  (rx_byte == CMD_RESEND) ? last_tx : RSP_ACK};
      q_cnt   <= (rx_byte == CMD_RESET) ? 2'd3 : (rx_byte == CMD_GET_ID) ? 2'd2 : 2'd1;
      enabled <= (rx_byte == CMD_ENABLE) ? 1'b1 :
                 (rx_byte == CMD_RESET || rx_byte == CMD_DISABLE || rx_byte == CMD_DEFAULTS) ? 1'b0 : enabled;
    end else if (tx_done) begin
      last_tx <= q[0];
      q       <= {RSP_ID, q[2], q[1]};
      q_cnt   <= q_cnt - 1'b1;
    end else if (accept && enabled) begin
      q     <= {pkt_dy[7:0], pkt_dx[7:0], {2'b00, pkt_dy[8], pkt_dx[8], 1'b1, pkt_btn}};
      q_cnt <= 2'd3;
    end
  end
endmodule

// File: tb/tb_ps2_mouse_dev.sv
// tb_ps2_mouse_dev: directed host-side model driving ps2_mouse_dev over open-collector lines.
module tb_ps2_mouse_dev;
  localparam int DH = 8;
  localparam int IM = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic h_clk_low = 1'b0, h_dat_low = 1'b0;
  wire ps2mclk, ps2mdat;
  logic pkt_valid = 1'b0;
  logic [2:0] pkt_btn = '0;
  logic [8:0] pkt_dx = '0, pkt_dy = '0;
  logic pkt_ready, enabled, cmd_valid, rx_err;
  logic [7:0] cmd_byte;
  int n_cmp = 0, n_bad = 0, cv_n = 0, err_n = 0;
  logic [7:0] last_cmd = '0;
  assign ps2mclk = h_clk_low ? 1'b0 : 1'bz;
  assign ps2mdat = h_dat_low ? 1'b0 : 1'bz;
  pullup (ps2mclk);
  pullup (ps2mdat);
  ps2_mouse_dev #(.DIV_HALF(DH), .INHIBIT_MIN(IM)) dut (
    .clk(clk), .reset_n(reset_n), .ps2mclk(ps2mclk), .ps2mdat(ps2mdat),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_btn(pkt_btn), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy),
    .enabled(enabled), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .rx_err(rx_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (cmd_valid) begin
      cv_n++;
      last_cmd = cmd_byte;
    end
    if (rx_err) err_n++;
  end
  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_fall(output logic ok);
    logic p;
    ok = 1'b0;
    p = ps2mclk;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = p === 1'b1 && ps2mclk === 1'b0;
      p = ps2mclk;
    end
  endtask
  task automatic host_rx(input string tag, input logic [7:0] exp_b, input logic exp_par);
    logic [10:0] f;
    logic ok, all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_fall(ok);
      all_ok &= ok;
      f[i] = ps2mdat;
    end
    check({tag, " edges"}, all_ok, 1);
    check({tag, " byte"}, f[8:1], exp_b);
    check({tag, " parity"}, f[9], exp_par);
    check({tag, " start/stop"}, {f[10], f[0]}, 2'b10);
  endtask
  task automatic host_send(input string tag, input logic [7:0] b, input logic par);
    logic [9:0] bits;
    logic ok, all_ok;
    bits = {1'b1, par, b};
    all_ok = 1'b1;
    h_clk_low = 1'b1;
    repeat (IM + 12) @(negedge clk);
    h_dat_low = 1'b1;
    repeat (4) @(negedge clk);
    h_clk_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_fall(ok);
      all_ok &= ok;
      h_dat_low = !bits[i];
    end
    wait_fall(ok);
    all_ok &= ok;
    check({tag, " edges"}, all_ok, 1);
    check({tag, " ack"}, ps2mdat, 0);
  endtask
  task automatic offer(input string tag, input logic [2:0] btn, input logic [8:0] dx, input logic [8:0] dy);
    logic acc;
    pkt_btn = btn;
    pkt_dx = dx;
    pkt_dy = dy;
    pkt_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 600 && !acc; n++) begin
      @(negedge clk);
      acc = pkt_ready;
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    check({tag, " accepted"}, acc, 1);
  endtask
  initial begin
    logic ok;
    logic p;
    int falls;
    repeat (3) @(negedge clk);
    check("rst pkt_ready", pkt_ready, 0);
    check("rst enabled", enabled, 0);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst cmd_byte", cmd_byte, 8'h00);
    check("rst rx_err", rx_err, 0);
    check("rst lines", {ps2mclk, ps2mdat}, 2'b11);
    reset_n = 1'b1;
    host_rx("bat aa", 8'hAA, 1'b1);
    host_rx("bat 00", 8'h00, 1'b1);
    check("bat enabled", enabled, 0);
    repeat (3 * DH) @(negedge clk);
    host_send("f4", 8'hF4, 1'b0);
    host_rx("f4 ack", 8'hFA, 1'b1);
    check("f4 cmd_valid count", cv_n, 1);
    check("f4 cmd byte", last_cmd, 8'hF4);
    check("f4 enabled", enabled, 1);
    offer("pkt1", 3'b001, 9'd5, 9'h1FD);
    host_rx("pkt1 b0", 8'h29, 1'b0);
    check("pkt busy ready", pkt_ready, 0);
    host_rx("pkt1 b1", 8'h05, 1'b1);
    host_rx("pkt1 b2", 8'hFD, 1'b0);
    offer("pkt2", 3'b000, 9'd5, 9'd0);
    host_rx("pkt2 b0", 8'h08, 1'b0);
    for (int i = 0; i < 4; i++) wait_fall(ok);
    for (int n = 0; n < 100 && ps2mclk !== 1'b1; n++) @(negedge clk);
    h_clk_low = 1'b1;
    check("abort bit4 data", ps2mdat, 0);
    repeat (DH + 4) @(negedge clk);
    check("abort data released", ps2mdat, 1);
    repeat (20) @(negedge clk);
    h_clk_low = 1'b0;
    host_rx("resend 05", 8'h05, 1'b1);
    host_rx("tail 00", 8'h00, 1'b1);
    repeat (3 * DH) @(negedge clk);
    host_send("f2 bad", 8'hF2, 1'b1);
    host_rx("f2 bad resp", 8'hFE, 1'b0);
    check("f2 bad rx_err count", err_n, 1);
    check("f2 bad no cmd_valid", cv_n, 1);
    repeat (3 * DH) @(negedge clk);
    host_send("f2", 8'hF2, 1'b0);
    host_rx("f2 ack", 8'hFA, 1'b1);
    host_rx("f2 id", 8'h00, 1'b1);
    check("f2 cmd_valid count", cv_n, 2);
    check("f2 cmd byte", last_cmd, 8'hF2);
    repeat (3 * DH) @(negedge clk);
    host_send("ff", 8'hFF, 1'b1);
    host_rx("ff ack", 8'hFA, 1'b1);
    host_rx("ff bat", 8'hAA, 1'b1);
    host_rx("ff id", 8'h00, 1'b1);
    check("ff enabled", enabled, 0);
    check("ff cmd_valid count", cv_n, 3);
    offer("pkt off", 3'b111, 9'd1, 9'd1);
    falls = 0;
    p = ps2mclk;
    repeat (100 * DH) begin
      @(negedge clk);
      if (p === 1'b1 && ps2mclk === 1'b0) falls++;
      p = ps2mclk;
    end
    check("disabled clock falls", falls, 0);
    check("disabled ready", pkt_ready, 1);
    host_send("fe", 8'hFE, 1'b0);
    host_rx("fe resend", 8'h00, 1'b1);
    check("fe cmd_byte", cmd_byte, 8'hFE);
    repeat (3 * DH) @(negedge clk);
    host_send("f4 again", 8'hF4, 1'b0);
    for (int i = 0; i < 3; i++) wait_fall(ok);
    check("midframe clock low", ps2mclk, 0);
    reset_n = 1'b0;
    #1;
    check("midframe reset lines", {ps2mclk, ps2mdat}, 2'b11);
    check("midframe reset enabled", enabled, 0);
    @(negedge clk);
    reset_n = 1'b1;
    host_rx("rebat aa", 8'hAA, 1'b1);
    host_rx("rebat 00", 8'h00, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
